// File: rtl/color_match_judge_if.sv
// Bus between the colour-match judge and its surroundings: colour generator
// inputs, game control inputs and the round/score outputs.
interface color_match_judge_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [11:0]        plats_in;
  logic [2:0]         ball_in;
  logic               land;
  logic [1:0]         land_idx;
  logic               color_req;
  logic [11:0]        plat_color;
  logic [2:0]         ball_color;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               game_over;

  modport master (
    output start, plats_in, ball_in, land, land_idx,
    input  color_req, plat_color, ball_color, hit, miss, score, lives, game_over
  );

  modport slave (
    input  start, plats_in, ball_in, land, land_idx,
    output color_req, plat_color, ball_color, hit, miss, score, lives, game_over
  );
endinterface

// File: rtl/color_match_judge.sv
// Colour-match game judge: picks a ball/platform colour set per round
// (guaranteeing at least one matching platform), judges each landing as a
// hit or a miss, and keeps score and remaining lives.
module color_match_judge #(
  parameter int LIVES   = 3,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  color_match_judge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_PLAY,
    S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [1:0]         reroll_q, reroll_d;
  logic [11:0]        plat_q, plat_d;
  logic [2:0]         ball_q, ball_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  // Colour of platform idx within a packed set of four platforms.
  function automatic logic [2:0] plat_at(input logic [11:0] plats, input logic [1:0] idx);
    case (idx)
      2'd0:    plat_at = plats[2:0];
      2'd1:    plat_at = plats[5:3];
      2'd2:    plat_at = plats[8:6];
      default: plat_at = plats[11:9];
    endcase
  endfunction

  // True when at least one platform carries the ball colour.
  function automatic logic any_match(input logic [11:0] plats, input logic [2:0] ball);
    any_match = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (plats[3*k +: 3] == ball) any_match = 1'b1;
    end
  endfunction

  // State and datapath registers; everything clears on reset, including the
  // colours, so the outputs read zero while the block is held in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      lives_q  <= '0;
      reroll_q <= '0;
      plat_q   <= '0;
      ball_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      reroll_q <= reroll_d;
      plat_q   <= plat_d;
      ball_q   <= ball_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Next-state logic: round setup with bounded rerolls, then landing judgement.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    reroll_d = reroll_q;
    plat_d   = plat_q;
    ball_d   = ball_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          score_d  = '0;
          lives_d  = 3'(LIVES);
          reroll_d = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        plat_d  = bus.plats_in;
        ball_d  = bus.ball_in;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (any_match(plat_q, ball_q)) begin
          reroll_d = '0;
          state_d  = S_PLAY;
        end else if (reroll_q != 2'd3) begin
          reroll_d = reroll_q + 2'd1;
          state_d  = S_LOAD;
        end else begin
          // Out of rerolls: make platform 0 match so the round is playable.
          plat_d[2:0] = ball_q;
          reroll_d    = '0;
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        if (bus.land) begin
          if (plat_at(plat_q, bus.land_idx) == ball_q) begin
            hit_d = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
            state_d = S_LOAD;
          end else begin
            miss_d  = 1'b1;
            lives_d = lives_q - 3'd1;
            state_d = (lives_q == 3'd1) ? S_OVER : S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.color_req  = (state_q == S_LOAD);
  assign bus.game_over  = (state_q == S_OVER);
  assign bus.plat_color = plat_q;
  assign bus.ball_color = ball_q;
  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;

endmodule

// File: tb/tb_color_match_judge.sv
// Directed bench for color_match_judge: one instance with the default score
// width for game flow, one with a 2-bit score for saturation and mid-round reset.
module tb_color_match_judge;

  logic clk = 1'b0;
  logic resetn_a = 1'b1;
  logic resetn_b = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  color_match_judge_if #(.SCORE_W(8)) ia ();
  color_match_judge_if #(.SCORE_W(2)) ib ();

  color_match_judge #(.LIVES(3), .SCORE_W(8)) dut_a (
    .clk    (clk),
    .resetn (resetn_a),
    .bus    (ia.slave)
  );

  color_match_judge #(.LIVES(3), .SCORE_W(2)) dut_b (
    .clk    (clk),
    .resetn (resetn_b),
    .bus    (ib.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ia.start = 0; ia.plats_in = '0; ia.ball_in = '0; ia.land = 0; ia.land_idx = '0;
    ib.start = 0; ib.plats_in = '0; ib.ball_in = '0; ib.land = 0; ib.land_idx = '0;
    #2;
    resetn_a = 0;
    resetn_b = 0;
    #1;
    checks++; if (ia.color_req !== 1'b0) begin errors++; $display("FAIL rst_color_req got=%0b want=0", ia.color_req); end
    checks++; if ({ia.hit, ia.miss, ia.game_over} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b want=000", {ia.hit, ia.miss, ia.game_over}); end
    checks++; if ({ia.score, ia.lives} !== 11'd0) begin errors++; $display("FAIL rst_counters got score=%0d lives=%0d want 0/0", ia.score, ia.lives); end
    checks++; if ({ia.plat_color, ia.ball_color} !== 15'd0) begin errors++; $display("FAIL rst_colors got plat=%o ball=%0d want 0/0", ia.plat_color, ia.ball_color); end
    tick();
    tick();
    resetn_a = 1;
    resetn_b = 1;
    tick();
    tick();
    checks++; if ({ia.color_req, ia.game_over} !== 2'b00) begin errors++; $display("FAIL idle_no_start got=%b want=00", {ia.color_req, ia.game_over}); end
  endtask

  task automatic test_start();
    ia.plats_in = 12'o1234;
    ia.ball_in  = 3'd3;
    ia.start    = 1;
    tick();
    ia.start = 0;
    checks++; if (ia.color_req !== 1'b1) begin errors++; $display("FAIL start_load_req got=%0b want=1", ia.color_req); end
    checks++; if (ia.lives !== 3'd3 || ia.score !== 8'd0) begin errors++; $display("FAIL start_counters got lives=%0d score=%0d want 3/0", ia.lives, ia.score); end
    tick();
    checks++; if (ia.color_req !== 1'b0) begin errors++; $display("FAIL start_req_once got=%0b want=0", ia.color_req); end
    checks++; if (ia.plat_color !== 12'o1234 || ia.ball_color !== 3'd3) begin errors++; $display("FAIL start_capture got plat=%o ball=%0d want 1234/3", ia.plat_color, ia.ball_color); end
    tick();
    checks++; if ({ia.color_req, ia.game_over, ia.hit, ia.miss} !== 4'b0000) begin errors++; $display("FAIL start_play got=%b want=0000", {ia.color_req, ia.game_over, ia.hit, ia.miss}); end
  endtask

  task automatic test_hit_miss();
    ia.land = 1; ia.land_idx = 2'd1;
    tick();
    checks++; if ({ia.hit, ia.miss} !== 2'b10) begin errors++; $display("FAIL hit_pulse got hit/miss=%b want=10", {ia.hit, ia.miss}); end
    checks++; if (ia.score !== 8'd1) begin errors++; $display("FAIL hit_score got=%0d want=1", ia.score); end
    checks++; if (ia.color_req !== 1'b1) begin errors++; $display("FAIL hit_reload got=%0b want=1", ia.color_req); end
    ia.land_idx = 2'd0;
    tick();
    checks++; if ({ia.hit, ia.miss} !== 2'b00) begin errors++; $display("FAIL land_in_load got hit/miss=%b want=00", {ia.hit, ia.miss}); end
    tick();
    checks++; if ({ia.hit, ia.miss} !== 2'b00 || ia.lives !== 3'd3 || ia.score !== 8'd1) begin errors++; $display("FAIL land_in_check got hm=%b lives=%0d score=%0d want 00/3/1", {ia.hit, ia.miss}, ia.lives, ia.score); end
    tick();
    ia.land = 0;
    checks++; if ({ia.hit, ia.miss} !== 2'b01) begin errors++; $display("FAIL miss_pulse got hit/miss=%b want=01", {ia.hit, ia.miss}); end
    checks++; if (ia.lives !== 3'd2 || ia.score !== 8'd1) begin errors++; $display("FAIL miss_counters got lives=%0d score=%0d want 2/1", ia.lives, ia.score); end
  endtask

  task automatic test_start_ignored();
    ia.start = 1;
    tick();
    tick();
    tick();
    ia.start = 0;
    checks++; if (ia.lives !== 3'd2 || ia.score !== 8'd1 || ia.color_req !== 1'b0) begin errors++; $display("FAIL start_ignored got lives=%0d score=%0d req=%0b want 2/1/0", ia.lives, ia.score, ia.color_req); end
  endtask

  task automatic test_game_over();
    ia.land = 1; ia.land_idx = 2'd0;
    tick();
    ia.land = 0;
    checks++; if (ia.miss !== 1'b1 || ia.lives !== 3'd1 || ia.game_over !== 1'b0) begin errors++; $display("FAIL over_miss2 got miss=%0b lives=%0d go=%0b want 1/1/0", ia.miss, ia.lives, ia.game_over); end
    tick();
    tick();
    ia.land = 1;
    tick();
    checks++; if (ia.miss !== 1'b1 || ia.lives !== 3'd0 || ia.game_over !== 1'b1) begin errors++; $display("FAIL over_miss3 got miss=%0b lives=%0d go=%0b want 1/0/1", ia.miss, ia.lives, ia.game_over); end
    tick();
    tick();
    checks++; if ({ia.hit, ia.miss} !== 2'b00 || ia.lives !== 3'd0 || ia.score !== 8'd1 || ia.game_over !== 1'b1) begin errors++; $display("FAIL over_hold got hm=%b lives=%0d score=%0d go=%0b want 00/0/1/1", {ia.hit, ia.miss}, ia.lives, ia.score, ia.game_over); end
    ia.land  = 0;
    ia.start = 1;
    tick();
    ia.start = 0;
    checks++; if (ia.lives !== 3'd3 || ia.score !== 8'd0 || ia.game_over !== 1'b0 || ia.color_req !== 1'b1) begin errors++; $display("FAIL over_restart got lives=%0d score=%0d go=%0b req=%0b want 3/0/0/1", ia.lives, ia.score, ia.game_over, ia.color_req); end
  endtask

  task automatic test_reroll();
    int reqs;
    ia.plats_in = 12'o0000;
    ia.ball_in  = 3'd5;
    reqs = (ia.color_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ia.color_req === 1'b1) reqs++;
    end
    checks++; if (reqs !== 4) begin errors++; $display("FAIL reroll_count got=%0d want=4", reqs); end
    checks++; if (ia.plat_color !== 12'o0005 || ia.ball_color !== 3'd5) begin errors++; $display("FAIL reroll_force got plat=%o ball=%0d want 0005/5", ia.plat_color, ia.ball_color); end
    ia.land = 1; ia.land_idx = 2'd0;
    tick();
    ia.land = 0;
    checks++; if (ia.hit !== 1'b1 || ia.score !== 8'd1) begin errors++; $display("FAIL reroll_play got hit=%0b score=%0d want 1/1", ia.hit, ia.score); end
  endtask

  task automatic test_saturation();
    int exp_s[4] = '{1, 2, 3, 3};
    ib.plats_in = 12'o1234;
    ib.ball_in  = 3'd3;
    ib.start    = 1;
    tick();
    ib.start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      ib.land = 1; ib.land_idx = 2'd1;
      tick();
      ib.land = 0;
      checks++; if (ib.hit !== 1'b1 || ib.score !== 2'(exp_s[i])) begin errors++; $display("FAIL sat_hit%0d got hit=%0b score=%0d want 1/%0d", i, ib.hit, ib.score, exp_s[i]); end
    end
  endtask

  task automatic test_reset_mid_round();
    tick();
    #3;
    resetn_b = 0;
    #1;
    checks++; if ({ib.color_req, ib.hit, ib.miss, ib.game_over} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl got=%b want=0000", {ib.color_req, ib.hit, ib.miss, ib.game_over}); end
    checks++; if (ib.score !== 2'd0 || ib.lives !== 3'd0 || ib.plat_color !== 12'd0 || ib.ball_color !== 3'd0) begin errors++; $display("FAIL midrst_data got score=%0d lives=%0d plat=%o ball=%0d want all 0", ib.score, ib.lives, ib.plat_color, ib.ball_color); end
    ib.land = 1; ib.land_idx = 2'd1;
    tick();
    tick();
    resetn_b = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({ib.hit, ib.miss, ib.color_req} !== 3'b000) begin errors++; $display("FAIL midrst_after%0d got hit/miss/req=%b want=000", i, {ib.hit, ib.miss, ib.color_req}); end
    end
    ib.land = 0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_miss();
    test_start_ignored();
    test_game_over();
    test_reroll();
    test_saturation();
    test_reset_mid_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
